// File: rtl/axis_ramp_src.sv
// AXI-Stream ramp test-pattern source: frames of M samples, natural or reversed order, NCHAN lanes.
// Build option: define AXIS_RAMP_SRC_THROTTLE_EN to insert LFSR-driven bubbles between beats.
`timescale 1ns/1ps
module axis_ramp_src #(
    parameter int WIDTH       = 16,
    parameter int M           = 64,
    parameter int NCHAN       = 1,
    parameter int LANE_STRIDE = 4096,
    parameter int FRAME_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     en,
    input  logic                     mode,
    input  logic [FRAME_W-1:0]       num_frames,
    output logic [WIDTH*NCHAN-1:0]   m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [FRAME_W-1:0]       frame_cnt,
    output logic                     done,
    output logic [1:0]               dbg_state
);
    // Handshake: a beat transfers when m_axis_tvalid & m_axis_tready on a rising clk edge;
    // once tvalid is high, tdata/tlast are frozen and tvalid stays high until that beat.

    localparam int SW = $clog2(M);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [SW-1:0]        s;
    logic [WIDTH-1:0]     f;
    logic [FRAME_W-1:0]   frames_lim;
    logic                 mode_r;
    logic                 beat, last_frame, finish, load, bubble, mode_eff;
    logic [SW-1:0]        s_eff;
    logic [WIDTH-1:0]     base;
    logic [WIDTH*NCHAN-1:0] data_nxt;

`ifdef AXIS_RAMP_SRC_THROTTLE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign bubble = (lfsr[1:0] == 2'b00);
`else
    assign bubble = 1'b0;
`endif

    assign beat       = m_axis_tvalid & m_axis_tready;
    assign last_frame = (frames_lim != '0) && (frame_cnt + FRAME_W'(1) == frames_lim);
    assign finish     = beat & m_axis_tlast & last_frame;
    assign load       = (state == ST_RUN) & en & ~bubble & ~finish & (~m_axis_tvalid | beat);

    // s/f count the next beat to be loaded; order is chosen once per frame at s==0.
    assign mode_eff = (s == '0) ? mode : mode_r;
    assign s_eff    = mode_eff ? ~s : s;
    assign base     = (f << SW) + WIDTH'(s_eff);

    always_comb begin
        data_nxt = '0;
        for (int k = 0; k < NCHAN; k++) begin
            data_nxt[k*WIDTH +: WIDTH] = base + WIDTH'(k * LANE_STRIDE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (finish) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_cnt     <= '0;
            frames_lim    <= '0;
            s             <= '0;
            f             <= '0;
            mode_r        <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            frames_lim    <= num_frames;
            frame_cnt     <= '0;
            s             <= '0;
            f             <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (beat && m_axis_tlast) frame_cnt <= frame_cnt + FRAME_W'(1);
            if (load) begin
                m_axis_tdata  <= data_nxt;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= (s == SW'(M - 1));
                mode_r        <= mode_eff;
                s             <= s + SW'(1);
                if (s == SW'(M - 1)) f <= f + WIDTH'(1);
            end else if (beat) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

    assign done      = (state == ST_DONE);
    assign dbg_state = state;

endmodule
